// File: rtl/rra_pkg.sv
// Shared types and helpers for the weighted-slice round-robin arbiter.
// The GUARD state is only reachable when RRA_GUARD_CYCLE_EN is defined.
package rra_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } state_e;

  localparam int N_REQ_DEF   = 4;
  localparam int SLICE_W_DEF = 4;
  localparam int SLICE_W_MAX = 16;

  // A programmed length of zero still gives the owner one cycle of tenure.
  function automatic logic [SLICE_W_MAX-1:0] slice_eff(input logic [SLICE_W_MAX-1:0] len);
    return (len == '0) ? SLICE_W_MAX'(1) : len;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotate-scan: first set request bit at or after ptr, wrapping modulo N_REQ.
module rr_priority_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic             found_o,
  output logic [ID_W-1:0]  idx_o
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] cand;

  // Scan from the farthest offset back to ptr so the nearest hit wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    cand    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_i} + (ID_W + 1)'(i);
      if (sum >= (ID_W + 1)'(N_REQ)) begin
        sum = sum - (ID_W + 1)'(N_REQ);
      end
      cand = sum[ID_W-1:0];
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_weighted_slices.sv
// Round-robin arbiter with per-requester weighted time slices and early release.
// Define RRA_GUARD_CYCLE_EN to insert a one-cycle gnt=0 turnaround on owner hand-off.
module rr_arbiter_weighted_slices
  import rra_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int SLICE_W = SLICE_W_DEF,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*SLICE_W-1:0] slice_cfg,
  output logic [N_REQ-1:0]         gnt,
  output logic [ID_W-1:0]          gnt_id,
  output logic                     gnt_valid,
  output logic                     slice_last
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [SLICE_W-1:0]  cnt_q, cnt_d;

  logic                pickFound;
  logic [ID_W-1:0]     pickIdx;
  logic [ID_W-1:0]     loadIdx;
  logic [ID_W-1:0]     nextPtr;
  logic [SLICE_W-1:0]  cntLoad;
  logic [SLICE_W_MAX-1:0] effLen;
  logic [SLICE_W-1:0]  sliceArr [N_REQ];
  logic                release_c;

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign sliceArr[g] = slice_cfg[g*SLICE_W +: SLICE_W];
  end

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .found_o (pickFound),
    .idx_o   (pickIdx)
  );

  // Leaving GUARD loads the owner chosen on entry; otherwise the fresh pick is loaded.
  always_comb begin
    loadIdx = (state_q == GUARD) ? owner_q : pickIdx;
    effLen  = slice_eff(SLICE_W_MAX'(sliceArr[loadIdx]));
    cntLoad = SLICE_W'(effLen - SLICE_W_MAX'(1));
    nextPtr = (pickIdx == ID_W'(N_REQ - 1)) ? '0 : pickIdx + ID_W'(1);
    release_c = !req[owner_q] || (cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pickFound) begin
          state_d = GRANT;
          owner_d = pickIdx;
          ptr_d   = nextPtr;
          cnt_d   = cntLoad;
        end
      end
      GRANT: begin
        // Drop and expiry in the same cycle fold into one release and one pointer update.
        if (release_c) begin
          if (pickFound) begin
`ifdef RRA_GUARD_CYCLE_EN
            if (pickIdx != owner_q) begin
              state_d = GUARD;
              owner_d = pickIdx;
              ptr_d   = nextPtr;
            end else begin
              owner_d = pickIdx;
              ptr_d   = nextPtr;
              cnt_d   = cntLoad;
            end
`else
            owner_d = pickIdx;
            ptr_d   = nextPtr;
            cnt_d   = cntLoad;
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - SLICE_W'(1);
        end
      end
`ifdef RRA_GUARD_CYCLE_EN
      GUARD: begin
        state_d = GRANT;
        cnt_d   = cntLoad;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    gnt        = '0;
    gnt_id     = '0;
    slice_last = 1'b0;
    if (state_q == GRANT) begin
      gnt[owner_q] = 1'b1;
      gnt_id       = owner_q;
      slice_last   = (cnt_q == '0);
    end
    gnt_valid = |gnt;
  end

endmodule
